// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared constants for the data-memory bus controller: size and FSM encodings.
package dmem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeIll  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StDone = 2'b10
  } state_e;

  // A request is legal when its size is defined and the address is naturally aligned.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size_e'(size))
      SizeByte: ok = 1'b1;
      SizeHalf: ok = ~addr_lo[0];
      SizeWord: ok = (addr_lo == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns a held core request into one external bus
// cycle with acknowledge handshake, alignment checking and a wait-state timeout.
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_mreq,
  input  logic        core_write,
  input  logic [1:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_err,
  output logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACKD_n
);

  // Count value at which an unacknowledged bus cycle is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Next-state and captured-request logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (core_mreq) begin
          if (req_legal(core_size, core_addr[1:0])) begin
            addr_d  = core_addr;
            size_d  = core_size;
            write_d = core_write;
            wdata_d = core_wdata;
            cnt_d   = 8'd0;
            err_d   = 1'b0;
            state_d = StBus;
          end else begin
            // Rejected without touching the bus; DAD/SIZE keep their old values.
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = StDone;
          end
        end
      end
      StBus: begin
        if (!ACKD_n) begin
          rdata_d = write_q ? 32'd0 : DDT;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and request registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus and core-side outputs decoded from the state register, so an async
  // reset releases the bus without waiting for a clock edge.
  always_comb begin
    MREQ       = (state_q == StBus);
    WRITE      = (state_q == StBus) && write_q;
    DAD        = addr_q;
    SIZE       = size_q;
    core_err   = (state_q == StDone) && err_q;
    core_rdata = rdata_q;
    core_stall = core_mreq && (state_q != StDone);
  end

  assign DDT = WRITE ? wdata_q : 32'bz;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed, table-driven bench for dmem_bus_ctrl with a small memory responder.
module tb_dmem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        core_mreq;
  logic        core_write;
  logic [1:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;
  logic [31:0] dad;
  wire  [31:0] ddt;
  logic        mreq;
  logic        write;
  logic [1:0]  size;
  logic        ackd_n;
  logic        mem_drv;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Released bus reads as all ones.
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (ddt[g]);
  end
  assign ddt = mem_drv ? mem_data : 32'bz;

  dmem_bus_ctrl #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_mreq (core_mreq),
    .core_write(core_write),
    .core_size (core_size),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .core_err  (core_err),
    .DAD       (dad),
    .DDT       (ddt),
    .MREQ      (mreq),
    .WRITE     (write),
    .SIZE      (size),
    .ACKD_n    (ackd_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;     // ack in BUS cycle index 'waits'; 255 = never
    logic [31:0] mdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_bus;   // number of BUS cycles
    int          exp_done;  // cycle index of DONE, request cycle = 0
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Enter just after a rising edge with the DUT idle; return likewise.
  task automatic run_txn(input vec_t v, input int id);
    int cyc = 0;
    int bus = 0;
    int done_cyc = -1;
    logic field_bad = 1'b0;
    core_mreq  = 1'b1;
    core_write = v.wr;
    core_size  = v.sz;
    core_addr  = v.addr;
    core_wdata = v.wdata;
    while (done_cyc < 0 && cyc < 20) begin
      @(negedge clk);
      if (mreq) begin
        if (write !== v.wr || dad !== v.addr || size !== v.sz || core_err !== 1'b0
            || core_stall !== 1'b1) field_bad = 1'b1;
        if (v.wr && ddt !== v.wdata) field_bad = 1'b1;
        if (!v.wr && ddt !== 32'hFFFF_FFFF) field_bad = 1'b1;
        if (bus == v.waits) begin
          ackd_n   = 1'b0;
          mem_drv  = !v.wr;
          mem_data = v.mdata;
        end
        bus++;
      end else begin
        ackd_n  = 1'b1;
        mem_drv = 1'b0;
        if (!core_stall) begin
          done_cyc = cyc;
          check($sformatf("v%0d err", id), 32'(core_err), 32'(v.exp_err));
          if (!v.wr || v.exp_err)
            check($sformatf("v%0d rdata", id), core_rdata, v.exp_rdata);
          core_mreq = 1'b0;
        end else if (core_err !== 1'b0) begin
          field_bad = 1'b1;
        end
      end
      cyc++;
    end
    check($sformatf("v%0d done_cycle", id), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("v%0d bus_cycles", id), 32'(bus), 32'(v.exp_bus));
    check($sformatf("v%0d bus_fields", id), 32'(field_bad), 32'd0);
    core_mreq = 1'b0;
    ackd_n    = 1'b1;
    mem_drv   = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle_after", id), {30'd0, mreq, core_err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,         0,   32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1, 2};
    vecs[1] = '{1'b1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 3,   32'h0,         1'b0, 32'h0,         4, 5};
    vecs[2] = '{1'b0, 2'b10, 32'h0000_0102, 32'h0,         0,   32'h1111_1111, 1'b1, 32'h0,         0, 1};
    vecs[3] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0,         0,   32'h2222_2222, 1'b1, 32'h0,         0, 1};
    vecs[4] = '{1'b0, 2'b00, 32'h0000_0103, 32'h0,         1,   32'h0000_00A5, 1'b0, 32'h0000_00A5, 2, 3};
    vecs[5] = '{1'b0, 2'b01, 32'h0000_0205, 32'h0,         0,   32'h3333_3333, 1'b1, 32'h0,         0, 1};
    vecs[6] = '{1'b1, 2'b10, 32'h0000_0300, 32'h1234_5678, 0,   32'h0,         1'b0, 32'h0,         1, 2};
    vecs[7] = '{1'b0, 2'b10, 32'h0000_0400, 32'h0,         255, 32'h0,         1'b1, 32'h0,         4, 5};
    vecs[8] = '{1'b0, 2'b01, 32'h0000_0206, 32'h0,         2,   32'h1234_0000, 1'b0, 32'h1234_0000, 3, 4};
    vecs[9] = '{1'b1, 2'b00, 32'h0000_0007, 32'h0000_5A00, 255, 32'h0,         1'b1, 32'h0,         4, 5};

    rst        = 1'b0;
    core_mreq  = 1'b0;
    core_write = 1'b0;
    core_size  = 2'b00;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    ackd_n     = 1'b1;
    mem_drv    = 1'b0;
    mem_data   = 32'h0;

    #3;
    check("reset mreq_write", {30'd0, mreq, write}, 32'd0);
    check("reset dad", dad, 32'h0);
    check("reset size", 32'(size), 32'd0);
    check("reset err_rdata", core_rdata | 32'(core_err), 32'd0);
    check("reset ddt_released", ddt, 32'hFFFF_FFFF);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    // Reset asserted in the second BUS cycle of a store.
    core_mreq  = 1'b1;
    core_write = 1'b1;
    core_size  = 2'b10;
    core_addr  = 32'h0000_0500;
    core_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    @(negedge clk);
    check("rstbus first_bus", 32'(mreq), 32'd1);
    @(negedge clk);
    check("rstbus ddt_driven", ddt, 32'hA5A5_A5A5);
    rst = 1'b0;
    #1;
    check("rstbus mreq_write", {30'd0, mreq, write}, 32'd0);
    check("rstbus ddt_released", ddt, 32'hFFFF_FFFF);
    check("rstbus dad", dad, 32'h0);
    core_mreq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_txn(vecs[0], 100);

    // Spurious acknowledge while idle, then a load with two wait states.
    ackd_n   = 1'b0;
    mem_drv  = 1'b1;
    mem_data = 32'hDEAD_DEAD;
    @(negedge clk);
    check("spur idle", {29'd0, mreq, core_err, core_stall}, 32'd0);
    @(posedge clk);
    #1;
    check("spur still_idle", {30'd0, mreq, core_err}, 32'd0);
    ackd_n  = 1'b1;
    mem_drv = 1'b0;
    begin
      vec_t sv;
      sv = '{1'b0, 2'b10, 32'h0000_0800, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 4};
      run_txn(sv, 101);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
